// File: rtl/icg_bank_hold.sv
// icg_bank_hold: bank of NCH negative-polarity (idle-high) integrated clock
// gates. Each channel has an OFF/ON/DRAIN hysteresis FSM that keeps its gated
// clock running for HOLD cycles after its enable request drops. The bank also
// reports run status, wake pulses and a bank-wide idle flag.
//
// Handshake note: this block has no valid/ready interfaces. E, TE and HOLD
// are level inputs sampled on the rising CLK edge. RUN, WAKE and IDLE are
// derived from registers and change only after a rising edge.
module icg_bank_hold #(
    parameter int NCH    = 4,
    parameter int HOLD_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    E,
    input  logic              TE,
    input  logic [HOLD_W-1:0] HOLD,
    output logic [NCH-1:0]    Q,
    output logic [NCH-1:0]    RUN,
    output logic [NCH-1:0]    WAKE,
    output logic              IDLE,
    output logic [2*NCH-1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state     [NCH];
    state_t            state_nxt [NCH];
    logic [HOLD_W-1:0] cnt       [NCH];
    logic [HOLD_W-1:0] cnt_nxt   [NCH];
    logic [NCH-1:0]    wake_q;
    logic [NCH-1:0]    wake_nxt;
    logic              idle_q;
    logic              idle_nxt;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    l;

    // Next-state, hold-off counter and wake detection for every channel
    always_comb begin
        wake_nxt = '0;
        idle_nxt = ~TE;
        for (int i = 0; i < NCH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                ST_OFF: begin
                    if (E[i]) begin
                        state_nxt[i] = ST_ON;
                        wake_nxt[i]  = 1'b1;
                    end
                end
                ST_ON: begin
                    if (!E[i]) begin
                        if (HOLD == '0) begin
                            state_nxt[i] = ST_OFF;
                        end else begin
                            // HOLD is only looked at here; later changes
                            // do not disturb a drain already in progress.
                            state_nxt[i] = ST_DRAIN;
                            cnt_nxt[i]   = HOLD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (E[i]) begin
                        // Re-request while draining: resume without a wake.
                        state_nxt[i] = ST_ON;
                    end else if (cnt[i] <= HOLD_W'(1)) begin
                        state_nxt[i] = ST_OFF;
                    end else begin
                        cnt_nxt[i] = cnt[i] - HOLD_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = ST_OFF;
                    cnt_nxt[i]   = '0;
                end
            endcase
            if (state_nxt[i] != ST_OFF) begin
                idle_nxt = 1'b0;
            end
        end
    end

    // State, counter and status registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= ST_OFF;
                cnt[i]   <= '0;
            end
            wake_q <= '0;
            idle_q <= 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            wake_q <= wake_nxt;
            idle_q <= idle_nxt;
        end
    end

    // Gate enables and status outputs decoded from the registered state
    always_comb begin
        RUN       = '0;
        state_dbg = '0;
        for (int i = 0; i < NCH; i++) begin
            RUN[i]             = (state[i] != ST_OFF);
            state_dbg[2*i +: 2] = state[i];
        end
        en   = RUN | {NCH{TE}};
        WAKE = wake_q;
        IDLE = idle_q;
    end

    // Gate latch: transparent while CLK is high, frozen through the low
    // phase, so the enable can never change while the output is low.
    always_latch begin
        if (RST) begin
            l <= '0;
        end else if (CLK) begin
            l <= en;
        end
    end

    // Idle-high gated clocks: low only in a low phase with the latch set
    assign Q = {NCH{CLK}} | ~l;

endmodule

// File: tb/tb_icg_bank_hold.sv
// Testbench for icg_bank_hold: table-driven vectors checked through an
// expected-value queue, plus hand-written reset-mid-drain and TE sequences.
module tb_icg_bank_hold;

    localparam int NCH    = 4;
    localparam int HOLD_W = 4;
    localparam int W      = 3*NCH + 1;

    logic              CLK;
    logic              RST;
    logic [NCH-1:0]    E;
    logic              TE;
    logic [HOLD_W-1:0] HOLD;
    logic [NCH-1:0]    Q;
    logic [NCH-1:0]    RUN;
    logic [NCH-1:0]    WAKE;
    logic              IDLE;
    logic [2*NCH-1:0]  state_dbg;

    typedef struct packed {
        logic [NCH-1:0]    e;
        logic              te;
        logic [HOLD_W-1:0] hold;
        logic [NCH-1:0]    run;
        logic [NCH-1:0]    wake;
    } vec_t;

    vec_t           vecs[$];
    logic [W-1:0]   exp_q[$];
    int             tests;
    int             fails;
    int             vec_idx;

    icg_bank_hold #(.NCH(NCH), .HOLD_W(HOLD_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .E(E),
        .TE(TE),
        .HOLD(HOLD),
        .Q(Q),
        .RUN(RUN),
        .WAKE(WAKE),
        .IDLE(IDLE),
        .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NCH-1:0] e, input logic te,
                                input logic [HOLD_W-1:0] hold,
                                input logic [NCH-1:0] run,
                                input logic [NCH-1:0] wake);
        vec_t v;
        v.e = e; v.te = te; v.hold = hold; v.run = run; v.wake = wake;
        return v;
    endfunction

    function automatic void add(input logic [NCH-1:0] e, input logic te,
                                input logic [HOLD_W-1:0] hold,
                                input logic [NCH-1:0] run,
                                input logic [NCH-1:0] wake);
        vecs.push_back(mk(e, te, hold, run, wake));
    endfunction

    function automatic void add_gap();
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) add(4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
    endfunction

    // Driver: called in a low phase; drives one vector, pushes expectations,
    // then checks status after the rising edge and Q in the next low phase.
    task automatic apply(input vec_t v);
        logic [W-1:0]   exp;
        logic [NCH-1:0] qlow;
        logic           idle;
        E    = v.e;
        TE   = v.te;
        HOLD = v.hold;
        idle = (v.run == '0) && !v.te;
        qlow = ~(v.run | {NCH{v.te}});
        exp_q.push_back({v.run, v.wake, idle, qlow});
        @(posedge CLK);
        #1;
        exp = exp_q.pop_front();
        check("run",   vec_idx, 32'(RUN),  32'(exp[3*NCH:2*NCH+1]));
        check("wake",  vec_idx, 32'(WAKE), 32'(exp[2*NCH:NCH+1]));
        check("idle",  vec_idx, 32'(IDLE), 32'(exp[NCH]));
        check("q_high", vec_idx, 32'(Q),   32'({NCH{1'b1}}));
        @(negedge CLK);
        #1;
        check("q_low", vec_idx, 32'(Q),    32'(exp[NCH-1:0]));
        vec_idx++;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        vec_idx = 0;
        RST  = 1'b1;
        E    = '0;
        TE   = 1'b0;
        HOLD = '0;

        // HOLD=3, E[0] high two cycles: five RUN cycles, five low pulses
        add(4'h1, 1'b0, 4'd3, 4'h1, 4'h1);
        add(4'h1, 1'b0, 4'd3, 4'h1, 4'h0);
        add(4'h0, 1'b0, 4'd3, 4'h1, 4'h0);
        add(4'h0, 1'b0, 4'd3, 4'h1, 4'h0);
        add(4'h0, 1'b0, 4'd3, 4'h1, 4'h0);
        add(4'h0, 1'b0, 4'd3, 4'h0, 4'h0);
        add_gap();
        // HOLD=0, single-cycle E[1]
        add(4'h2, 1'b0, 4'd0, 4'h2, 4'h2);
        add(4'h0, 1'b0, 4'd0, 4'h0, 4'h0);
        add_gap();
        // HOLD=4, E[2] re-asserted at CNT=2, then four more cycles
        add(4'h4, 1'b0, 4'd4, 4'h4, 4'h4);
        add(4'h0, 1'b0, 4'd4, 4'h4, 4'h0);
        add(4'h0, 1'b0, 4'd4, 4'h4, 4'h0);
        add(4'h0, 1'b0, 4'd4, 4'h4, 4'h0);
        add(4'h4, 1'b0, 4'd4, 4'h4, 4'h0);
        for (int k = 0; k < 4; k++) add(4'h0, 1'b0, 4'd4, 4'h4, 4'h0);
        add(4'h0, 1'b0, 4'd4, 4'h0, 4'h0);
        add_gap();
        // TE forces gates open without touching state or wake
        add(4'h0, 1'b1, 4'd0, 4'h0, 4'h0);
        add(4'h0, 1'b1, 4'd0, 4'h0, 4'h0);
        add(4'h8, 1'b1, 4'd0, 4'h8, 4'h8);
        add(4'h0, 1'b0, 4'd0, 4'h0, 4'h0);
        add_gap();
        // HOLD loaded as 7, changed to 1 mid-drain; the next drain uses 1
        add(4'h8, 1'b0, 4'd7, 4'h8, 4'h8);
        add(4'h0, 1'b0, 4'd7, 4'h8, 4'h0);
        for (int k = 0; k < 6; k++) add(4'h0, 1'b0, 4'd1, 4'h8, 4'h0);
        add(4'h0, 1'b0, 4'd1, 4'h0, 4'h0);
        add(4'h8, 1'b0, 4'd1, 4'h8, 4'h8);
        add(4'h0, 1'b0, 4'd1, 4'h8, 4'h0);
        add(4'h0, 1'b0, 4'd1, 4'h0, 4'h0);
        add_gap();
        // Simultaneous transitions on several channels, HOLD=2
        add(4'hF, 1'b0, 4'd2, 4'hF, 4'hF);
        add(4'h5, 1'b0, 4'd2, 4'hF, 4'h0);
        add(4'h0, 1'b0, 4'd2, 4'hF, 4'h0);
        add(4'h0, 1'b0, 4'd2, 4'h5, 4'h0);
        add(4'hA, 1'b0, 4'd2, 4'hA, 4'hA);
        add(4'h0, 1'b0, 4'd0, 4'h0, 4'h0);

        // Reset state, checked in both clock phases
        #1;
        check("rst_run",  0, 32'(RUN),  32'h0);
        check("rst_wake", 0, 32'(WAKE), 32'h0);
        check("rst_idle", 0, 32'(IDLE), 32'h1);
        check("rst_q",    0, 32'(Q),    32'hF);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst_q_low", 0, 32'(Q), 32'hF);
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset asserted mid-drain (HOLD=5, CNT=3) during a gated low phase
        apply(mk(4'h1, 1'b0, 4'd5, 4'h1, 4'h1));
        apply(mk(4'h0, 1'b0, 4'd5, 4'h1, 4'h0));
        apply(mk(4'h0, 1'b0, 4'd5, 4'h1, 4'h0));
        apply(mk(4'h0, 1'b0, 4'd5, 4'h1, 4'h0));
        RST = 1'b1;
        #1;
        check("mid_rst_q",    1, 32'(Q),    32'hF);
        check("mid_rst_run",  1, 32'(RUN),  32'h0);
        check("mid_rst_wake", 1, 32'(WAKE), 32'h0);
        check("mid_rst_idle", 1, 32'(IDLE), 32'h1);
        @(posedge CLK);
        #1;
        check("mid_rst_run_edge", 1, 32'(RUN), 32'h0);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        apply(mk(4'h0, 1'b0, 4'd5, 4'h0, 4'h0));
        apply(mk(4'h0, 1'b0, 4'd5, 4'h0, 4'h0));

        // TE raised and dropped inside low phases: latch holds until high
        TE = 1'b1;
        #2;
        check("te_rise_low", 2, 32'(Q), 32'hF);
        @(posedge CLK);
        #1;
        check("te_idle_on",  2, 32'(IDLE), 32'h0);
        check("te_run",      2, 32'(RUN),  32'h0);
        @(negedge CLK);
        #1;
        check("te_q_low",    2, 32'(Q), 32'h0);
        TE = 1'b0;
        #2;
        check("te_fall_low", 2, 32'(Q), 32'h0);
        @(posedge CLK);
        #1;
        check("te_idle_off", 2, 32'(IDLE), 32'h1);
        @(negedge CLK);
        #1;
        check("te_q_closed", 2, 32'(Q), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
